// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
//   Shared instruction-set constants and types. The instruction memory,
//   the CPU fetch path and the instruction loader use these so that word and
//   address widths stay consistent across the design.
//
//   ADDR_W   : instruction memory address width (4096 words)
//   INSTR_W  : instruction word width
//   BYTES_PW : stream bytes per instruction word, ceil(INSTR_W/8)
//   instr_t  : one instruction word
//   iaddr_t  : one instruction memory address
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int ADDR_W   = 12;
    localparam int INSTR_W  = 19;
    localparam int BYTES_PW = (INSTR_W + 7) / 8;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  iaddr_t;

endpackage

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//   Write-side companion to the instruction memory. It accepts a byte stream
//   over a valid/ready handshake and packs every three bytes (little-endian,
//   top byte truncated to 3 bits) into one 19-bit instruction word. Each word
//   is written to consecutive addresses starting at base_addr. While a load is
//   in progress the CPU is held through cpu_hold.
//
// Ports
//   clk         in   1          system clock, all state on posedge
//   rst         in   1          asynchronous active-low reset
//   start       in   1          pulse: begin a load at base_addr (IDLE only)
//   base_addr   in   ADDR_W     first write address, sampled on accepted start
//   byte_in     in   8          stream byte
//   byte_valid  in   1          byte_in valid
//   last        in   1          byte_in is the final byte of the final word
//   byte_ready  out  1          loader accepts a byte this cycle
//   mem_we      out  1          instruction memory write enable, 1 cycle/word
//   mem_addr    out  ADDR_W     write address (holds when mem_we=0)
//   mem_wdata   out  INSTR_W    write data    (holds when mem_we=0)
//   busy        out  1          load in progress
//   cpu_hold    out  1          same as busy; CPU must stall and hold PC
//   done        out  1          pulse: load completed cleanly
//   error       out  1          sticky abort flag, cleared by next start
//   word_count  out  ADDR_W+1   words written since the last accepted start
// -----------------------------------------------------------------------------
module instruction_loader
    import isa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               last,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    word_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PW - 1);

    loader_state_t state;
    logic [1:0]    idx;        // position of the next byte within the word
    logic [15:0]   word_lo;    // bytes 0 and 1 of the word being assembled
    iaddr_t        addr;       // address the current word will be written to
    logic          last_flag;  // the word being written closes the load

    // Only byte_in[2:0] of the third byte lands in the word.
    logic unused_top_bits;
    assign unused_top_bits = ^byte_in[7:3];

    // Every handshake/status output is a pure decode of the state register.
    assign byte_ready = (state == COLLECT);
    assign busy       = (state == COLLECT) || (state == WRITE);
    assign cpu_hold   = busy;
    assign mem_we     = (state == WRITE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            word_lo    <= 16'd0;
            addr       <= '0;
            last_flag  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr       <= base_addr;
                        error      <= 1'b0;
                        word_count <= '0;
                        idx        <= 2'd0;
                        last_flag  <= 1'b0;
                        state      <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (byte_valid) begin
                        if (idx == LAST_IDX) begin
                            // Word complete: present it on the write port now so
                            // mem_addr/mem_wdata only change when a write happens.
                            mem_addr  <= addr;
                            mem_wdata <= {byte_in[2:0], word_lo};
                            last_flag <= last;
                            state     <= WRITE;
                        end else begin
                            if (idx == 2'd0) begin
                                word_lo[7:0] <= byte_in;
                            end else begin
                                word_lo[15:8] <= byte_in;
                            end
                            if (last) begin
                                // Stream ended mid-word: discard it and abort.
                                error <= 1'b1;
                                state <= IDLE;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                    end
                end

                WRITE: begin
                    word_count <= word_count + (ADDR_W + 1)'(1);
                    if (last_flag) begin
                        state <= DONE;
                    end else if (addr == '1) begin
                        // Top of memory reached with more data pending; refuse
                        // to wrap onto address 0.
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        addr  <= addr + 1'b1;
                        idx   <= 2'd0;
                        state <= COLLECT;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        last;
    logic        byte_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [18:0] mem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [12:0] word_count;

    instruction_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .last       (last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Write monitor: records every write, counts done pulses, hold gaps and
    // writes that do not directly follow a byte acceptance.
    logic [30:0] wr_q[$];
    int  done_cnt    = 0;
    int  hold_gap    = 0;
    int  bad_we      = 0;
    bit  expect_hold = 0;
    bit  acc_prev    = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            if (!acc_prev) bad_we++;
        end
        if (done === 1'b1) done_cnt++;
        if (expect_hold && cpu_hold !== 1'b1) hold_gap++;
        acc_prev = (byte_valid === 1'b1) && (byte_ready === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b);
        start = 1'b1;
        base_addr = b;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
        bit ok = 0;
        for (int g = 0; g < gap; g++) step();
        byte_valid = 1'b1;
        byte_in = b;
        last = l;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready === 1'b1) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        byte_valid = 1'b0;
        last = 1'b0;
        checks++;
        if (!ok) $display("FAIL accept_timeout byte=%h not accepted within 20 cycles", b);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        last = 1'b0;
        step();
        step();
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, word_count} !== '0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, word_count});
        else passes++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        wr_q.delete();
        done_cnt = 0;
        do_start(12'd7);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hC3, 1'b1, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd7 || mem_wdata !== 19'h30000)
            $display("FAIL t1_write got we=%b addr=%0d data=%h exp we=1 addr=7 data=30000",
                     mem_we, mem_addr, mem_wdata);
        else passes++;
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL t1_done got done=%b busy=%b exp 1/0", done, busy);
        else passes++;
        checks++;
        if (word_count !== 13'd1 || error !== 1'b0)
            $display("FAIL t1_status got wc=%0d err=%b exp wc=1 err=0", word_count, error);
        else passes++;
        step();
        step();
        checks++;
        if (wr_q.size() !== 1 || done_cnt !== 1)
            $display("FAIL t1_counts got writes=%0d dones=%0d exp 1/1", wr_q.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_two_words();
        wr_q.delete();
        done_cnt = 0;
        hold_gap = 0;
        do_start(12'd20);
        expect_hold = 1;
        checks++;
        if (cpu_hold !== 1'b1) $display("FAIL t2_hold_start got=%b exp=1", cpu_hold);
        else passes++;
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'hAB, 1'b0, 0);
        send_byte(8'hCD, 1'b0, 0);
        send_byte(8'hFE, 1'b1, 0);
        step();
        expect_hold = 0;
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0)
            $display("FAIL t2_done got done=%b hold=%b exp 1/0", done, cpu_hold);
        else passes++;
        step();
        step();
        checks++;
        if (wr_q.size() !== 2) $display("FAIL t2_nwrites got=%0d exp=2", wr_q.size());
        else begin
            passes++;
            checks++;
            if (wr_q[0] !== {12'd20, 19'h53412}) $display("FAIL t2_word0 got=%h exp=%h", wr_q[0], {12'd20, 19'h53412});
            else passes++;
            checks++;
            if (wr_q[1] !== {12'd21, 19'h6CDAB}) $display("FAIL t2_word1 got=%h exp=%h", wr_q[1], {12'd21, 19'h6CDAB});
            else passes++;
        end
        checks++;
        if (done_cnt !== 1 || hold_gap !== 0 || word_count !== 13'd2)
            $display("FAIL t2_status got dones=%0d holdgaps=%0d wc=%0d exp 1/0/2", done_cnt, hold_gap, word_count);
        else passes++;
    endtask

    task automatic run_four(input bit gaps);
        logic [7:0] bytes [12] = '{8'h11, 8'h22, 8'hF9, 8'h33, 8'h44, 8'h0A,
                                   8'h55, 8'h66, 8'h07, 8'h77, 8'h88, 8'hFC};
        logic [30:0] expw;
        wr_q.delete();
        bad_we = 0;
        do_start(12'd100);
        for (int i = 0; i < 12; i++)
            send_byte(bytes[i], (i == 11), gaps ? int'($urandom_range(0, 3)) : 0);
        step();
        step();
        checks++;
        if (wr_q.size() !== 4) $display("FAIL t3_nwrites gaps=%0d got=%0d exp=4", gaps, wr_q.size());
        else begin
            passes++;
            for (int w = 0; w < 4; w++) begin
                expw = {12'(100 + w), bytes[3*w+2][2:0], bytes[3*w+1], bytes[3*w]};
                checks++;
                if (wr_q[w] !== expw) $display("FAIL t3_word%0d gaps=%0d got=%h exp=%h", w, gaps, wr_q[w], expw);
                else passes++;
            end
        end
        checks++;
        if (bad_we !== 0) $display("FAIL t3_stall_we gaps=%0d got=%0d exp=0", gaps, bad_we);
        else passes++;
    endtask

    task automatic test_gaps();
        run_four(1'b0);
        run_four(1'b1);
    endtask

    task automatic test_partial_word();
        wr_q.delete();
        done_cnt = 0;
        do_start(12'd50);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b1, 0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL t4_abort got err=%b busy=%b done=%b exp 1/0/0", error, busy, done);
        else passes++;
        step();
        step();
        checks++;
        if (wr_q.size() !== 0 || done_cnt !== 0)
            $display("FAIL t4_nowrite got writes=%0d dones=%0d exp 0/0", wr_q.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_top_address();
        wr_q.delete();
        done_cnt = 0;
        do_start(12'd4095);
        checks++;
        if (error !== 1'b0) $display("FAIL t5_err_cleared got=%b exp=0", error);
        else passes++;
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd4095 || mem_wdata !== 19'h30201)
            $display("FAIL t5_write got we=%b addr=%0d data=%h exp 1/4095/30201", mem_we, mem_addr, mem_wdata);
        else passes++;
        step();
        checks++;
        if (error !== 1'b1 || word_count !== 13'd1 || busy !== 1'b0)
            $display("FAIL t5_abort got err=%b wc=%0d busy=%b exp 1/1/0", error, word_count, busy);
        else passes++;
        byte_valid = 1'b1;
        byte_in = 8'h04;
        for (int i = 0; i < 4; i++) step();
        byte_valid = 1'b0;
        checks++;
        if (wr_q.size() !== 1 || done_cnt !== 0 || byte_ready !== 1'b0)
            $display("FAIL t5_nowrap got writes=%0d dones=%0d ready=%b exp 1/0/0", wr_q.size(), done_cnt, byte_ready);
        else passes++;
    endtask

    task automatic test_start_ignored_and_reset();
        wr_q.delete();
        do_start(12'd300);
        send_byte(8'hAA, 1'b0, 0);
        do_start(12'd999);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b1, 0);
        step();
        step();
        checks++;
        if (wr_q.size() !== 1 || wr_q[0] !== {12'd300, 19'h4BBAA})
            $display("FAIL t6_ignore_start got writes=%0d first=%h exp 1/%h",
                     wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 31'h0, {12'd300, 19'h4BBAA});
        else passes++;

        do_start(12'd400);
        send_byte(8'h5A, 1'b0, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, word_count} !== '0)
            $display("FAIL t6_async_reset got=%h exp=0",
                     {byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error, word_count});
        else passes++;
        step();
        rst = 1'b1;
        step();
        wr_q.delete();
        done_cnt = 0;
        do_start(12'd401);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b1, 0);
        step();
        step();
        checks++;
        if (wr_q.size() !== 1 || wr_q[0] !== {12'd401, 19'h30201} || done_cnt !== 1)
            $display("FAIL t6_reload got writes=%0d dones=%0d first=%h exp 1/1/%h",
                     wr_q.size(), done_cnt, wr_q.size() > 0 ? wr_q[0] : 31'h0, {12'd401, 19'h30201});
        else passes++;
        checks++;
        if (word_count !== 13'd1 || error !== 1'b0)
            $display("FAIL t6_status got wc=%0d err=%b exp 1/0", word_count, error);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_gaps();
        test_partial_word();
        test_top_address();
        test_start_ignored_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
